regfile_addr_sequencer: RTL

//  Registered, handshaked successor to the combinational implicit-register decoder.
//  - Accepts IR words from fetch via a valid/ready handshake.
//  - Emits the register-file address implied by the opcode, one cycle after acceptance.
//  - Expands PUSH/POP into a two-beat sequence: SP read, then SP write-back.
//  - Sits between the IR register and the register-file address mux.

---
 rtl/regfile_addr_sequencer_pkg.sv | 32 +++
 rtl/implicit_reg_decode.sv | 51 +++++
 rtl/regfile_addr_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_addr_sequencer_pkg.sv
// Shared constants for the register-file address sequencer: opcodes, implicit register indices,
// FSM state encoding and SP direction values.
package regfile_addr_sequencer_pkg;

    localparam int unsigned INSTRUCTION_LENGTH   = 16;
    localparam int unsigned TOTAL_ADDRESS_LENGTH = 4;
    localparam int unsigned OPCODE_W             = 5;

    // Opcodes (top OPCODE_W bits of the IR)
    localparam logic [OPCODE_W-1:0] OP_SETADDL = 5'h08;
    localparam logic [OPCODE_W-1:0] OP_SETADDH = 5'h09;
    localparam logic [OPCODE_W-1:0] OP_LDIL    = 5'h0A;
    localparam logic [OPCODE_W-1:0] OP_LDIH    = 5'h0B;
    localparam logic [OPCODE_W-1:0] OP_PUSH    = 5'h10;
    localparam logic [OPCODE_W-1:0] OP_POP     = 5'h11;

    // Implicit register indices
    localparam logic [3:0] REG_RLI  = 4'd12;
    localparam logic [3:0] REG_RADR = 4'd13;
    localparam logic [3:0] REG_SP   = 4'd15;

    localparam logic SP_DIR_DEC = 1'b1;
    localparam logic SP_DIR_INC = 1'b0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEmit = 2'd1,
        StSpRd = 2'd2,
        StSpWb = 2'd3
    } seq_state_e;

endpackage

// File: rtl/implicit_reg_decode.sv
// Combinational decode of an IR word into its implicit register-file address and
// the stack / pairing attributes used by the sequencer.
module implicit_reg_decode
    import regfile_addr_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_W = INSTRUCTION_LENGTH,
    parameter int unsigned ADDR_W  = TOTAL_ADDRESS_LENGTH
) (
    input  logic [INSTR_W-1:0] ir,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr,
    output logic               is_stack,
    output logic               is_push,
    output logic               is_low,
    output logic               is_high,
    output logic               pair_sel
);

    logic [OPCODE_W-1:0] opcode;
    logic                unused_operand;

    assign opcode         = ir[INSTR_W-1 -: OPCODE_W];
    assign unused_operand = ^ir[INSTR_W-OPCODE_W-1:0];

    // pair_sel: 1 selects the LDI pair, 0 the SETADD pair
    always_comb begin
        hit      = 1'b0;
        addr     = '0;
        is_stack = 1'b0;
        is_push  = 1'b0;
        is_low   = 1'b0;
        is_high  = 1'b0;
        pair_sel = 1'b0;
        case (opcode)
            OP_SETADDL: begin hit = 1'b1; addr = ADDR_W'(REG_RADR); is_low  = 1'b1; end
            OP_SETADDH: begin hit = 1'b1; addr = ADDR_W'(REG_RADR); is_high = 1'b1; end
            OP_LDIL: begin
                hit = 1'b1; addr = ADDR_W'(REG_RLI); is_low = 1'b1; pair_sel = 1'b1;
            end
            OP_LDIH: begin
                hit = 1'b1; addr = ADDR_W'(REG_RLI); is_high = 1'b1; pair_sel = 1'b1;
            end
            OP_PUSH: begin
                hit = 1'b1; addr = ADDR_W'(REG_SP); is_stack = 1'b1; is_push = 1'b1;
            end
            OP_POP:  begin hit = 1'b1; addr = ADDR_W'(REG_SP); is_stack = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_addr_sequencer.sv
// Registered, handshaked implicit-register address sequencer; PUSH/POP expand into an SP read
// beat followed by an SP write-back beat. Optional pairing check enabled by PAIR_CHECK_EN.
module regfile_addr_sequencer
    import regfile_addr_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_W = INSTRUCTION_LENGTH,
    parameter int unsigned ADDR_W  = TOTAL_ADDRESS_LENGTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ir_valid,
    input  logic [INSTR_W-1:0] ir,
    output logic               ir_ready,
    output logic               addr_valid,
    output logic               set_reg_address,
    output logic [ADDR_W-1:0]  reg_address,
    output logic               sp_update,
    output logic               sp_dir,
    output logic               busy
`ifdef PAIR_CHECK_EN
    ,
    output logic               pair_err
`endif
);

    seq_state_e        state_q, state_d;
    logic              addr_valid_q, addr_valid_d;
    logic              set_q, set_d;
    logic [ADDR_W-1:0] reg_address_q, reg_address_d;
    logic              sp_update_q, sp_update_d;
    logic              sp_dir_q, sp_dir_d;
    logic              push_q, push_d;

    logic              dec_hit, dec_is_stack, dec_is_push, dec_is_low, dec_is_high, dec_pair_sel;
    logic [ADDR_W-1:0] dec_addr;
    logic              accept;

    implicit_reg_decode #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_decode (
        .ir       (ir),
        .hit      (dec_hit),
        .addr     (dec_addr),
        .is_stack (dec_is_stack),
        .is_push  (dec_is_push),
        .is_low   (dec_is_low),
        .is_high  (dec_is_high),
        .pair_sel (dec_pair_sel)
    );

    assign ir_ready = !rst && (state_q != StSpRd);
    assign accept   = ir_valid && ir_ready;

    always_comb begin
        state_d       = state_q;
        addr_valid_d  = 1'b0;
        set_d         = 1'b0;
        reg_address_d = reg_address_q;
        sp_update_d   = 1'b0;
        sp_dir_d      = 1'b0;
        push_d        = push_q;
        if (state_q == StSpRd) begin
            state_d       = StSpWb;
            addr_valid_d  = 1'b1;
            set_d         = 1'b1;
            reg_address_d = ADDR_W'(REG_SP);
            sp_update_d   = 1'b1;
            sp_dir_d      = push_q ? SP_DIR_DEC : SP_DIR_INC;
        end else if (accept) begin
            addr_valid_d = 1'b1;
            if (dec_is_stack) begin
                state_d       = StSpRd;
                push_d        = dec_is_push;
                set_d         = 1'b1;
                reg_address_d = ADDR_W'(REG_SP);
            end else begin
                state_d = StEmit;
                set_d   = dec_hit;
                if (dec_hit) reg_address_d = dec_addr;
            end
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_valid_q  <= 1'b0;
            set_q         <= 1'b0;
            reg_address_q <= '0;
            sp_update_q   <= 1'b0;
            sp_dir_q      <= 1'b0;
            push_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_valid_q  <= addr_valid_d;
            set_q         <= set_d;
            reg_address_q <= reg_address_d;
            sp_update_q   <= sp_update_d;
            sp_dir_q      <= sp_dir_d;
            push_q        <= push_d;
        end
    end

    assign addr_valid      = addr_valid_q;
    assign set_reg_address = set_q;
    assign reg_address     = reg_address_q;
    assign sp_update       = sp_update_q;
    assign sp_dir          = sp_dir_q;
    assign busy            = (state_q == StSpRd) || (state_q == StSpWb);

`ifdef PAIR_CHECK_EN
    logic pend_ldi_q, pend_ldi_d, pend_setadd_q, pend_setadd_d, pair_err_q, pair_err_d;
    logic pend_sel;

    assign pend_sel = dec_pair_sel ? pend_ldi_q : pend_setadd_q;

    // Low op re-arms an already set flag -> error; high op without a pending low -> error
    always_comb begin
        pend_ldi_d    = pend_ldi_q;
        pend_setadd_d = pend_setadd_q;
        pair_err_d    = 1'b0;
        if (accept && (dec_is_low || dec_is_high)) begin
            pair_err_d = dec_is_low ? pend_sel : !pend_sel;
            if (dec_pair_sel) pend_ldi_d    = dec_is_low;
            else              pend_setadd_d = dec_is_low;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_ldi_q    <= 1'b0;
            pend_setadd_q <= 1'b0;
            pair_err_q    <= 1'b0;
        end else begin
            pend_ldi_q    <= pend_ldi_d;
            pend_setadd_q <= pend_setadd_d;
            pair_err_q    <= pair_err_d;
        end
    end

    assign pair_err = pair_err_q;
`else
    logic unused_pair;
    assign unused_pair = ^{dec_is_low, dec_is_high, dec_pair_sel};
`endif

endmodule
